// File: rtl/ram_arbiter.sv
// Arbiter and cycle sequencer for the shared 8-bit external SRAM port.
// Serves video, CPU and DMA requesters with a fixed-length access and a one-cycle done strobe.
module ram_arbiter #(
  parameter int AW            = 19,
  parameter int ACCESS_CYCLES = 2,
  parameter int DMA_STARVE    = 8
) (
  input  logic          clk28,
  input  logic          rst,

  input  logic          video_req,
  input  logic [AW-1:0] video_addr,
  output logic          video_done,
  output logic [7:0]    video_rdata,

  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_done,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_stall,

  input  logic          dma_req,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_wdata,
  output logic          dma_done,
  output logic [7:0]    dma_rdata,

  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_dout,
  output logic          ram_doe,
  input  logic [7:0]    ram_din,
  output logic          ram_nwe,
  output logic          ram_noe
);

  localparam int CW = $clog2(ACCESS_CYCLES);
  localparam int WW = $clog2(DMA_STARVE + 1);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(ACCESS_CYCLES - 1);
  localparam logic [WW-1:0] STARVE_MAX = WW'(DMA_STARVE);

  typedef enum logic { S_IDLE, S_ACC } state_t;
  typedef enum logic [1:0] { OWN_VIDEO, OWN_CPU, OWN_DMA } owner_t;

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  logic            wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   ram_a_q, ram_a_d;
  logic [7:0]      ram_dout_q, ram_dout_d;
  logic            ram_nwe_q, ram_nwe_d;
  logic            ram_noe_q, ram_noe_d;
  logic            ram_doe_q, ram_doe_d;
  logic            video_done_q, video_done_d;
  logic            cpu_done_q, cpu_done_d;
  logic            dma_done_q, dma_done_d;
  logic [7:0]      video_rdata_q, video_rdata_d;
  logic [7:0]      cpu_rdata_q, cpu_rdata_d;
  logic [7:0]      dma_rdata_q, dma_rdata_d;
  logic [WW-1:0]   dma_wait_q, dma_wait_d;

  logic            video_elig, cpu_elig, dma_elig;
  logic            grant_valid;
  owner_t          grant_owner;
  logic [AW-1:0]   grant_addr;
  logic            grant_wr;
  logic [7:0]      grant_wdata;

  // A requester is invisible to arbitration while its done strobe is high, so a
  // held request is not granted a second time before the requester can drop it.
  assign video_elig = video_req & ~video_done_q;
  assign cpu_elig   = cpu_req   & ~cpu_done_q;
  assign dma_elig   = dma_req   & ~dma_done_q;

  // NOTE: every signal assigned in an always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWN_CPU;
    grant_addr  = cpu_addr;
    grant_wr    = cpu_wr;
    grant_wdata = cpu_wdata;
    if (video_elig) begin
      grant_valid = 1'b1;
      grant_owner = OWN_VIDEO;
      grant_addr  = video_addr;
      grant_wr    = 1'b0;
      grant_wdata = 8'h00;
    end else if (dma_elig && (dma_wait_q == STARVE_MAX)) begin
      grant_valid = 1'b1;
      grant_owner = OWN_DMA;
      grant_addr  = dma_addr;
      grant_wr    = dma_wr;
      grant_wdata = dma_wdata;
    end else if (cpu_elig) begin
      grant_valid = 1'b1;
    end else if (dma_elig) begin
      grant_valid = 1'b1;
      grant_owner = OWN_DMA;
      grant_addr  = dma_addr;
      grant_wr    = dma_wr;
      grant_wdata = dma_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      owner_q       <= OWN_VIDEO;
      wr_q          <= 1'b0;
      cnt_q         <= '0;
      ram_a_q       <= '0;
      ram_dout_q    <= 8'h00;
      ram_nwe_q     <= 1'b1;
      ram_noe_q     <= 1'b1;
      ram_doe_q     <= 1'b0;
      video_done_q  <= 1'b0;
      cpu_done_q    <= 1'b0;
      dma_done_q    <= 1'b0;
      video_rdata_q <= 8'h00;
      cpu_rdata_q   <= 8'h00;
      dma_rdata_q   <= 8'h00;
      dma_wait_q    <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      wr_q          <= wr_d;
      cnt_q         <= cnt_d;
      ram_a_q       <= ram_a_d;
      ram_dout_q    <= ram_dout_d;
      ram_nwe_q     <= ram_nwe_d;
      ram_noe_q     <= ram_noe_d;
      ram_doe_q     <= ram_doe_d;
      video_done_q  <= video_done_d;
      cpu_done_q    <= cpu_done_d;
      dma_done_q    <= dma_done_d;
      video_rdata_q <= video_rdata_d;
      cpu_rdata_q   <= cpu_rdata_d;
      dma_rdata_q   <= dma_rdata_d;
      dma_wait_q    <= dma_wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_valid) state_d = S_ACC;
      S_ACC:   if (cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered so the SRAM pins change only on clk28 edges.
  always_comb begin
    owner_d       = owner_q;
    wr_d          = wr_q;
    cnt_d         = cnt_q;
    ram_a_d       = ram_a_q;
    ram_dout_d    = ram_dout_q;
    ram_nwe_d     = 1'b1;
    ram_noe_d     = 1'b1;
    ram_doe_d     = 1'b0;
    video_done_d  = 1'b0;
    cpu_done_d    = 1'b0;
    dma_done_d    = 1'b0;
    video_rdata_d = video_rdata_q;
    cpu_rdata_d   = cpu_rdata_q;
    dma_rdata_d   = dma_rdata_q;
    dma_wait_d    = dma_wait_q;

    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          owner_d    = grant_owner;
          wr_d       = grant_wr;
          cnt_d      = CNT_LOAD;
          ram_a_d    = grant_addr;
          ram_dout_d = grant_wdata;
          if (grant_wr) begin
            ram_doe_d = 1'b1;
            ram_nwe_d = 1'b0;
          end else begin
            ram_noe_d = 1'b0;
          end
          if (grant_owner == OWN_DMA) begin
            dma_wait_d = '0;
          end else if ((grant_owner == OWN_CPU) && dma_elig && (dma_wait_q != STARVE_MAX)) begin
            dma_wait_d = dma_wait_q + WW'(1);
          end
        end
      end
      S_ACC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          if (wr_q) begin
            ram_doe_d = 1'b1;
            // WE rises for the last cycle so data is still driven after the write edge.
            ram_nwe_d = (cnt_q == CW'(1));
          end else begin
            ram_noe_d = 1'b0;
          end
        end else begin
          case (owner_q)
            OWN_VIDEO: begin
              video_done_d = 1'b1;
              if (!wr_q) video_rdata_d = ram_din;
            end
            OWN_CPU: begin
              cpu_done_d = 1'b1;
              if (!wr_q) cpu_rdata_d = ram_din;
            end
            default: begin
              dma_done_d = 1'b1;
              if (!wr_q) dma_rdata_d = ram_din;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  assign video_done  = video_done_q;
  assign video_rdata = video_rdata_q;
  assign cpu_done    = cpu_done_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_stall   = cpu_req & ~cpu_done_q;
  assign dma_done    = dma_done_q;
  assign dma_rdata   = dma_rdata_q;
  assign ram_a       = ram_a_q;
  assign ram_dout    = ram_dout_q;
  assign ram_doe     = ram_doe_q;
  assign ram_nwe     = ram_nwe_q;
  assign ram_noe     = ram_noe_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: single accesses, arbitration order, DMA starvation,
// reset during a write and the no-regrant rule on a held request.
module tb_ram_arbiter;

  localparam int AW = 19;

  logic          clk28;
  logic          rst;
  logic          video_req;
  logic [AW-1:0] video_addr;
  logic          video_done;
  logic [7:0]    video_rdata;
  logic          cpu_req, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_done;
  logic [7:0]    cpu_rdata;
  logic          cpu_stall;
  logic          dma_req, dma_wr;
  logic [AW-1:0] dma_addr;
  logic [7:0]    dma_wdata;
  logic          dma_done;
  logic [7:0]    dma_rdata;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_dout;
  logic          ram_doe;
  logic [7:0]    ram_din;
  logic          ram_nwe, ram_noe;

  int n_checks = 0;
  int n_fail   = 0;

  int   n_done;
  byte  log_who  [0:63];
  int   log_step [0:63];
  int   log_wait [0:63];
  int   a_log    [0:127];

  ram_arbiter #(.AW(AW), .ACCESS_CYCLES(2), .DMA_STARVE(8)) dut (
    .clk28       (clk28),
    .rst         (rst),
    .video_req   (video_req),
    .video_addr  (video_addr),
    .video_done  (video_done),
    .video_rdata (video_rdata),
    .cpu_req     (cpu_req),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_done    (cpu_done),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .dma_req     (dma_req),
    .dma_wr      (dma_wr),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_done    (dma_done),
    .dma_rdata   (dma_rdata),
    .ram_a       (ram_a),
    .ram_dout    (ram_dout),
    .ram_doe     (ram_doe),
    .ram_din     (ram_din),
    .ram_nwe     (ram_nwe),
    .ram_noe     (ram_noe)
  );

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk28);
    #1;
  endtask

  // Run up to max_steps cycles, logging each done strobe; optionally drop the
  // request of a requester once its done has been seen.
  task automatic collect(input int want, input int max_steps, input bit auto_drop);
    n_done = 0;
    for (int s = 1; s <= max_steps && n_done < want; s++) begin
      step();
      a_log[s] = int'(ram_a);
      if (video_done) begin
        log_who[n_done] = "V"; log_step[n_done] = s; log_wait[n_done] = int'(dut.dma_wait_q);
        n_done++;
        if (auto_drop) video_req = 1'b0;
      end
      if (cpu_done) begin
        log_who[n_done] = "C"; log_step[n_done] = s; log_wait[n_done] = int'(dut.dma_wait_q);
        n_done++;
        if (auto_drop) cpu_req = 1'b0;
      end
      if (dma_done) begin
        log_who[n_done] = "D"; log_step[n_done] = s; log_wait[n_done] = int'(dut.dma_wait_q);
        n_done++;
        if (auto_drop) dma_req = 1'b0;
      end
    end
  endtask

  initial begin
    byte exp_who;

    rst = 1'b1;
    video_req = 1'b0; video_addr = '0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
    dma_req = 1'b0; dma_wr = 1'b0; dma_addr = '0; dma_wdata = 8'h00;
    ram_din = 8'h00;

    // Reset state
    step();
    step();
    check("rst_nwe",   ram_nwe, 1);
    check("rst_noe",   ram_noe, 1);
    check("rst_doe",   ram_doe, 0);
    check("rst_a",     ram_a, 0);
    check("rst_dout",  ram_dout, 0);
    check("rst_dones", {video_done, cpu_done, dma_done}, 0);
    check("rst_rdata", {video_rdata, cpu_rdata, dma_rdata}, 0);
    check("rst_wait",  dut.dma_wait_q, 0);
    @(negedge clk28);
    rst = 1'b0;

    // 1. CPU read
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 19'h12345; ram_din = 8'hA5;
    #1;
    check("t1_stall_req", cpu_stall, 1);
    step();
    check("t1_a",        ram_a, 19'h12345);
    check("t1_noe_c1",   ram_noe, 0);
    check("t1_nwe_c1",   ram_nwe, 1);
    check("t1_done_c1",  cpu_done, 0);
    step();
    check("t1_noe_c2",   ram_noe, 0);
    check("t1_nwe_c2",   ram_nwe, 1);
    check("t1_done_c2",  cpu_done, 0);
    check("t1_stall_c2", cpu_stall, 1);
    step();
    check("t1_done",     cpu_done, 1);
    check("t1_rdata",    cpu_rdata, 8'hA5);
    check("t1_noe_rel",  ram_noe, 1);
    check("t1_stall_dn", cpu_stall, 0);
    cpu_req = 1'b0;
    step();
    check("t1_done_off", cpu_done, 0);

    // 2. CPU write
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 19'h00100; cpu_wdata = 8'h5C; ram_din = 8'hEE;
    #1;
    check("t2_stall_req", cpu_stall, 1);
    step();
    check("t2_a",       ram_a, 19'h00100);
    check("t2_dout",    ram_dout, 8'h5C);
    check("t2_doe_c1",  ram_doe, 1);
    check("t2_nwe_c1",  ram_nwe, 0);
    check("t2_noe_c1",  ram_noe, 1);
    check("t2_stall_c1", cpu_stall, 1);
    step();
    check("t2_doe_c2",  ram_doe, 1);
    check("t2_nwe_c2",  ram_nwe, 1);
    check("t2_dout_c2", ram_dout, 8'h5C);
    check("t2_done_c2", cpu_done, 0);
    step();
    check("t2_done",    cpu_done, 1);
    check("t2_doe_rel", ram_doe, 0);
    check("t2_rdata",   cpu_rdata, 8'hA5);
    check("t2_stall_dn", cpu_stall, 0);
    cpu_req = 1'b0; cpu_wr = 1'b0;
    step();

    // 3. Simultaneous video, cpu and dma requests
    video_req = 1'b1; video_addr = 19'h00AAA;
    cpu_req   = 1'b1; cpu_addr   = 19'h00BBB;
    dma_req   = 1'b1; dma_addr   = 19'h00CCC; dma_wr = 1'b0;
    ram_din   = 8'h3C;
    collect(3, 20, 1'b1);
    check("t3_count", n_done, 3);
    check("t3_who0",  log_who[0], "V");
    check("t3_who1",  log_who[1], "C");
    check("t3_who2",  log_who[2], "D");
    check("t3_step0", log_step[0], 3);
    check("t3_step1", log_step[1], 6);
    check("t3_step2", log_step[2], 9);
    check("t3_a_v",   a_log[1], 32'h00AAA);
    check("t3_a_c",   a_log[4], 32'h00BBB);
    check("t3_a_d",   a_log[7], 32'h00CCC);
    check("t3_vdata", video_rdata, 8'h3C);
    check("t3_cdata", cpu_rdata, 8'h3C);
    check("t3_ddata", dma_rdata, 8'h3C);
    step();
    step();
    check("t3_idle_noe", ram_noe, 1);
    check("t3_idle_done", {video_done, cpu_done, dma_done}, 0);

    // 4. All three held: video interleaves; CPU wins 8 times before DMA gets one slot
    video_req = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b0; dma_req = 1'b1; dma_wr = 1'b0;
    collect(34, 120, 1'b0);
    check("t4_count", n_done, 34);
    for (int g = 1; g <= 34; g++) begin
      if (g % 2 == 1) exp_who = "V";
      else if (g == 18) exp_who = "D";
      else exp_who = "C";
      check($sformatf("t4_who%0d", g), log_who[g-1], exp_who);
    end
    check("t4_wait_sat",  log_wait[15], 8);
    check("t4_wait_clr",  log_wait[17], 0);
    check("t4_wait_sat2", log_wait[33], 8);
    video_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    repeat (4) step();

    // 5. Reset in the first cycle of a write
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 19'h00200; cpu_wdata = 8'h77;
    step();
    check("t5_nwe_pre", ram_nwe, 0);
    check("t5_doe_pre", ram_doe, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_nwe_async", ram_nwe, 1);
    check("t5_doe_async", ram_doe, 0);
    check("t5_noe_async", ram_noe, 1);
    step();
    check("t5_done_r1", cpu_done, 0);
    step();
    check("t5_done_r2", cpu_done, 0);
    cpu_req = 1'b0; cpu_wr = 1'b0;
    @(negedge clk28);
    rst = 1'b0;
    step();
    check("t5_done_post", cpu_done, 0);
    cpu_req = 1'b1; cpu_addr = 19'h00300; ram_din = 8'h96;
    step();
    check("t5_a",     ram_a, 19'h00300);
    check("t5_noe",   ram_noe, 0);
    step();
    step();
    check("t5_done",  cpu_done, 1);
    check("t5_rdata", cpu_rdata, 8'h96);
    cpu_req = 1'b0;
    step();

    // 6. Request held through its done cycle, then dropped
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 19'h00400; ram_din = 8'h4B;
    step();
    check("t6_a", ram_a, 19'h00400);
    step();
    step();
    check("t6_done",  dma_done, 1);
    check("t6_rdata", dma_rdata, 8'h4B);
    step();
    check("t6_noregrant_noe", ram_noe, 1);
    check("t6_done_off",      dma_done, 0);
    dma_req = 1'b0;
    step();
    step();
    check("t6_quiet_noe",  ram_noe, 1);
    check("t6_quiet_done", dma_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
